instr_fetch: RTL and testbench
==============================

# instr_fetch

Fetch stage that sits directly upstream of the instruction memory and directly upstream of decode. It owns the program counter and drives the word address into the combinational instruction memory. It captures the returned word, together with its PC, into a small buffer and presents it to decode over a valid/ready handshake. Control-flow redirects from execute flush the buffer and restart fetch at the new PC.

## Interface
- MEM_ADDR_SIZE, 6, width of the instruction-memory word address (memory holds 2^MEM_ADDR_SIZE words)
- RESET_PC, 32'h0000_0000, byte PC loaded on reset
- BUF_DEPTH, 2, entries in the fetch buffer; power of two, ≥2
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous assert, active-low
- imem_addr  out  MEM_ADDR_SIZE  word address to instruction memory; equals fetch_pc[MEM_ADDR_SIZE+1:2]
- imem_data  in  32  combinational read data for imem_addr, valid in the same cycle
- redirect_valid  in  1  single-cycle pulse: restart fetch at redirect_pc
- redirect_pc  in  32  byte-address redirect target
- out_valid  out  1  buffer head holds an instruction
- out_ready  in  1  decode accepts the head this cycle
- out_instr  out  32  instruction word at buffer head
- out_pc  out  32  byte PC of out_instr
- out_fault  out  1  head is a fetch fault (only with FETCH_FAULT_EN; tied 0 otherwise)

## Operation
- State: fetch_pc (32b), FIFO of {pc, instr, fault} entries, count (clog2(BUF_DEPTH)+1 bits), halted flag (fault build only).
- pop = out_valid & out_ready.
- push = !redirect_valid & !halted & (count < BUF_DEPTH | pop).
  - Simultaneous push and pop is allowed when the buffer is full, giving 1 instruction/cycle sustained.
- On push: enqueue {fetch_pc, imem_data, 0}; fetch_pc <= fetch_pc + 4.
  - The addition is 32-bit and wraps modulo 2^32.
  - imem_addr wraps naturally in the memory word space.
- On redirect_valid:
  - The FIFO is cleared and fetch_pc <= redirect_pc.
  - halted is cleared.
  - No push occurs that cycle.
  - Redirect has priority over push and halt.
  - A pop in the same cycle still counts as delivered; it is decode's job to discard it.
- Buffer stalls (full, no pop): fetch_pc holds and imem_addr holds.
- out_* always reflect the FIFO head. out_instr/out_pc are don't-care when out_valid=0 but must be stable while out_valid=1 and out_ready=0.

## Timing
- Reset values: fetch_pc=RESET_PC, count=0, out_valid=0, out_instr=0, out_pc=0, out_fault=0, halted=0.
- Reset asserted mid-operation discards all buffered entries immediately (asynchronous).
- Fetch latency is 1 cycle:
  - The first rising edge after rst_n deasserts pushes the word at RESET_PC.
  - out_valid=1 from that edge.
- Redirect latency is 2 edges:
  - Edge of the redirect cycle: buffer empty, out_valid=0.
  - Next edge: head = word at redirect_pc.
- Steady state with out_ready=1: one instruction per cycle, consecutive PCs +4.
- Full buffer: out_valid stays 1 and push resumes in the cycle out_ready returns.

## Configuration
- FETCH_FAULT_EN defined: a fault exists when fetch_pc[1:0]≠0 or fetch_pc[31:MEM_ADDR_SIZE+2]≠0.
  - A fault pushes one entry {fetch_pc, 32'h0000_0013 (NOP), fault=1}.
  - It then sets halted: no further pushes and fetch_pc holds.
  - halted is cleared only by redirect or reset.
- FETCH_FAULT_EN undefined:
  - No fault checking; low and high PC bits are ignored and the address truncates.
  - out_fault is tied 0 and there is no halted state.

## Structure
- fetch_pkg: fetch_entry_t struct {logic[31:0] pc; logic[31:0] instr; logic fault;}, NOP_INSTR = 32'h0000_0013, PC_STEP = 4.
- Sub-module fetch_fifo: synchronous FIFO parameterised on BUF_DEPTH, storing fetch_entry_t.
  - Ports: push, pop, flush, head, count, full, empty.
  - Pointers are clog2(BUF_DEPTH) bits and wrap.
  - flush has priority over push.
- instr_fetch holds the PC, halt logic and push/flush control.

## Test plan
- Reset, memory words 0..3 = 0xA0..0xA3, out_ready=1 -> out_pc 0,4,8,12 on consecutive cycles with matching instr; out_valid first high one edge after rst_n rises.
- out_ready=0 for 5 cycles from reset -> count saturates at 2, imem_addr holds at 2, head stays pc 0; on out_ready=1 -> pcs 0,4,8 back-to-back with no bubble.
- Redirect to 0x20 while buffer full and out_ready=1 -> next cycle out_valid=0, following cycle out_pc=0x20, instr=mem[8].
- fetch_pc reaches 0xFC with MEM_ADDR_SIZE=6, no fault build -> next out_pc=0x100, imem_addr wraps to 0, instr=mem[0].
- FETCH_FAULT_EN, redirect to 0x102 -> one entry pc=0x102, fault=1, instr=0x13, then out_valid=0 indefinitely until a redirect to 0x0 resumes normal fetch.
- rst_n pulsed low mid-stream with 2 entries buffered -> out_valid drops asynchronously; after release, out_pc restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries; flush empties it and wins over push.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int BUF_DEPTH = 2,
    localparam int PTR_W     = $clog2(BUF_DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  fetch_entry_t       din,
    output fetch_entry_t       head,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty
);

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    fetch_entry_t     mem_q [BUF_DEPTH];
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(BUF_DEPTH));
    assign count   = count_q;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Head reads as zero while empty so the outputs show clean values out of reset.
    assign head = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads instruction memory, buffers {pc, instr} for decode.
// Optional fault checking and halting is enabled with `define FETCH_FAULT_EN.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter  int          MEM_ADDR_SIZE = 6,
    parameter  logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter  int          BUF_DEPTH     = 2,
    localparam int          CNT_W         = $clog2(BUF_DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic [MEM_ADDR_SIZE-1:0] imem_addr,
    input  logic [31:0]              imem_data,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pc,
    output logic                     out_fault
);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic             pop, push, has_room, advance;
    fetch_entry_t     push_entry, head;
    logic [CNT_W-1:0] count;
    logic             full, empty;

    assign imem_addr = fetch_pc_q[MEM_ADDR_SIZE+1:2];
    assign out_valid = ~empty;
    assign pop       = ~empty & out_ready;
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign has_room  = (count < CNT_W'(BUF_DEPTH)) | (full & pop);

`ifdef FETCH_FAULT_EN
    logic halted_q, halted_d, fault_now;

    assign fault_now = (fetch_pc_q[1:0] != 2'b00) |
                       (fetch_pc_q[31:MEM_ADDR_SIZE+2] != '0);
    assign push      = ~redirect_valid & ~halted_q & has_room;
    assign advance   = push & ~fault_now;

    always_comb begin
        push_entry = '{pc: fetch_pc_q, instr: imem_data, fault: 1'b0};
        halted_d   = halted_q;
        if (fault_now) push_entry = '{pc: fetch_pc_q, instr: NOP_INSTR, fault: 1'b1};
        if (redirect_valid)       halted_d = 1'b0;
        else if (push && fault_now) halted_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) halted_q <= 1'b0;
        else        halted_q <= halted_d;
    end
`else
    assign push       = ~redirect_valid & has_room;
    assign advance    = push;
    assign push_entry = '{pc: fetch_pc_q, instr: imem_data, fault: 1'b0};
`endif

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) fetch_pc_d = redirect_pc;
        else if (advance)   fetch_pc_d = fetch_pc_q + PC_STEP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fetch_pc_q <= RESET_PC;
        else        fetch_pc_q <= fetch_pc_d;
    end

    fetch_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (push_entry),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign out_instr = head.instr;
    assign out_pc    = head.pc;
    // Without fault checking every entry is pushed with fault=0, so this is constant 0.
    assign out_fault = head.fault;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_instr_fetch;

    localparam int          AW    = 6;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [AW-1:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_fault;

    logic [31:0] mem [64];
    assign imem_data = mem[imem_addr];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } ref_t;

    ref_t        mq[$];
    logic [31:0] mpc;
    logic        mhalt;
    int          total = 0;
    int          bad = 0;

    instr_fetch #(.MEM_ADDR_SIZE(AW), .RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_fault(out_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [AW-1:0] model_addr();
        return AW'((mpc / 4) % 64);
    endfunction

    // Reference: one rising edge of the fetch stage, from the behavioural rules.
    task automatic model_edge(input logic rdy, input logic redir, input logic [31:0] rpc);
        ref_t e;
        logic do_pop;
        logic flt;
        do_pop = (mq.size() != 0) && rdy;
        if (redir) begin
            mq.delete();
            mpc   = rpc;
            mhalt = 1'b0;
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (!mhalt && mq.size() < DEPTH) begin
                flt = 1'b0;
`ifdef FETCH_FAULT_EN
                flt = (mpc % 4 != 0) || (mpc >= 32'd256);
`endif
                e.pc    = mpc;
                e.instr = flt ? 32'h0000_0013 : mem[(mpc / 4) % 64];
                e.fault = flt;
                mq.push_back(e);
                if (flt) mhalt = 1'b1;
                else     mpc = mpc + 32'd4;
            end
        end
    endtask

    task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc);
        @(negedge clk);
        out_ready      = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        @(posedge clk);
        model_edge(rdy, redir, rpc);
        #1;
        redirect_valid = 1'b0;
    endtask

    task automatic model_reset();
        mq.delete();
        mpc   = RPC;
        mhalt = 1'b0;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #3;
        total++;
        if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0 || out_fault !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got valid=%b pc=%h instr=%h fault=%b, want 0/0/0/0",
                     out_valid, out_pc, out_instr, out_fault);
        end
        total++;
        if (imem_addr !== AW'(RPC / 4)) begin
            bad++;
            $display("FAIL reset_addr: got %0d want %0d", imem_addr, RPC / 4);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'h0);
            total++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * i) || out_instr !== 32'hA0 + 32'(i)) begin
                bad++;
                $display("FAIL stream_%0d: got valid=%b pc=%h instr=%h, want 1 pc=%h instr=%h",
                         i, out_valid, out_pc, out_instr, 4 * i, 32'hA0 + 32'(i));
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'h0);
            total++;
            if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== mem[0]) begin
                bad++;
                $display("FAIL stall_head_%0d: got valid=%b pc=%h instr=%h, want 1 pc=0 instr=%h",
                         i, out_valid, out_pc, out_instr, mem[0]);
            end
        end
        total++;
        if (imem_addr !== AW'(2)) begin
            bad++;
            $display("FAIL stall_addr: got %0d want 2", imem_addr);
        end
        for (int i = 1; i <= 3; i++) begin
            step(1'b1, 1'b0, 32'h0);
            total++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * i) || out_instr !== mem[i]) begin
                bad++;
                $display("FAIL stall_resume_%0d: got valid=%b pc=%h instr=%h, want 1 pc=%h instr=%h",
                         i, out_valid, out_pc, out_instr, 4 * i, mem[i]);
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h20);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL redirect_flush: got valid=%b want 0", out_valid);
        end
        step(1'b1, 1'b0, 32'h0);
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h20 || out_instr !== mem[8]) begin
            bad++;
            $display("FAIL redirect_target: got valid=%b pc=%h instr=%h, want 1 pc=20 instr=%h",
                     out_valid, out_pc, out_instr, mem[8]);
        end
    endtask

`ifndef FETCH_FAULT_EN
    task automatic test_wrap();
        step(1'b1, 1'b1, 32'hF8);
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        total++;
        if (out_pc !== 32'hFC || imem_addr !== AW'(0)) begin
            bad++;
            $display("FAIL wrap_addr: got pc=%h addr=%0d, want pc=fc addr=0", out_pc, imem_addr);
        end
        step(1'b1, 1'b0, 32'h0);
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== mem[0]) begin
            bad++;
            $display("FAIL wrap_head: got valid=%b pc=%h instr=%h, want 1 pc=100 instr=%h",
                     out_valid, out_pc, out_instr, mem[0]);
        end
    endtask
`else
    task automatic test_fault();
        step(1'b1, 1'b1, 32'h102);
        step(1'b1, 1'b0, 32'h0);
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h102 || out_fault !== 1'b1 || out_instr !== 32'h13) begin
            bad++;
            $display("FAIL fault_entry: got valid=%b pc=%h fault=%b instr=%h, want 1 102 1 13",
                     out_valid, out_pc, out_fault, out_instr);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'h0);
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL fault_halt_%0d: got valid=%b want 0", i, out_valid);
            end
        end
        step(1'b1, 1'b1, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_fault !== 1'b0 || out_instr !== mem[0]) begin
            bad++;
            $display("FAIL fault_resume: got valid=%b pc=%h fault=%b instr=%h, want 1 0 0 %h",
                     out_valid, out_pc, out_fault, out_instr, mem[0]);
        end
    endtask
`endif

    task automatic test_random();
        logic        rdy, redir;
        logic [31:0] rpc;
        for (int i = 0; i < 300; i++) begin
            rdy   = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 15) == 0);
            rpc   = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 63) * 4)
                                                : ($urandom & 32'hFFFF_FFFC);
            step(rdy, redir, rpc);
            total++;
            if (out_valid !== (mq.size() != 0)) begin
                bad++;
                $display("FAIL rnd_valid_%0d: got %b want %b", i, out_valid, mq.size() != 0);
            end
            total++;
            if (imem_addr !== model_addr()) begin
                bad++;
                $display("FAIL rnd_addr_%0d: got %0d want %0d", i, imem_addr, model_addr());
            end
            if (mq.size() != 0) begin
                total++;
                if (out_pc !== mq[0].pc || out_instr !== mq[0].instr || out_fault !== mq[0].fault) begin
                    bad++;
                    $display("FAIL rnd_head_%0d: got pc=%h instr=%h fault=%b, want pc=%h instr=%h fault=%b",
                             i, out_pc, out_instr, out_fault, mq[0].pc, mq[0].instr, mq[0].fault);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL areset_prefill: got valid=%b want 1", out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_pc !== 32'h0) begin
            bad++;
            $display("FAIL areset_drop: got valid=%b pc=%h, want 0 0", out_valid, out_pc);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 1'b0, 32'h0);
        total++;
        if (out_valid !== 1'b1 || out_pc !== RPC || out_instr !== mem[RPC / 4]) begin
            bad++;
            $display("FAIL areset_restart: got valid=%b pc=%h instr=%h, want 1 pc=%h instr=%h",
                     out_valid, out_pc, out_instr, RPC, mem[RPC / 4]);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        for (int i = 0; i < 4; i++) mem[i] = 32'hA0 + 32'(i);
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
`ifndef FETCH_FAULT_EN
        test_wrap();
`else
        test_fault();
`endif
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
